// File: rtl/patp_pkg.sv
// Shared types for the PATP control sequencer: opcodes, ALU operations and sequencer states.
package patp_pkg;

    localparam int OPCODE_W  = 3;
    localparam int OPERAND_W = 5;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_JMP   = 3'd4,
        OP_BZ    = 3'd5,
        OP_INC   = 3'd6,
        OP_HALT  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2,
        ALU_INC  = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // LOAD, STORE, ADD and SUB occupy the lower half of the opcode space.
    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/patp_ctrl.sv
// PATP fetch/decode/execute sequencer driving memory, IR, PC and accumulator strobes.
// Optional memory-ack timeout enabled by defining PATP_CTRL_MEM_TIMEOUT_EN.
module patp_ctrl
    import patp_pkg::*;
#(
    parameter int OPCODE_W    = patp_pkg::OPCODE_W,
    parameter int OPERAND_W   = patp_pkg::OPERAND_W,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [OPERAND_W-1:0] operand,
    input  logic                 acc_zero,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 ir_we,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 acc_we,
    output logic [1:0]           alu_op,
    output logic                 halted,
    output logic                 err
);

    state_e  state;
    state_e  state_nxt;
    opcode_e op;
    alu_op_e alu_sel;
    logic    timeout;
    logic    unused_operand;

    assign op             = opcode_e'(opcode);
    assign alu_op         = alu_sel;
    assign unused_operand = ^operand;

`ifdef PATP_CTRL_MEM_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       err_q;

    // Fires on the last ack-less cycle; an ack in that same cycle still completes normally.
    assign timeout = !mem_ack && (wait_cnt == 4'(MEM_TIMEOUT - 1));
    assign err     = err_q;
`else
    localparam int UNUSED_TIMEOUT = MEM_TIMEOUT;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        acc_we    = 1'b0;
        alu_sel   = ALU_PASS;
        halted    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we     = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (timeout) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (is_mem_op(op)) begin
                    state_nxt = ST_MEM;
                end else begin
                    case (op)
                        OP_JMP:  pc_load = 1'b1;
                        OP_BZ:   pc_load = acc_zero;
                        OP_INC: begin
                            acc_we  = 1'b1;
                            alu_sel = ALU_INC;
                        end
                        default: halted = 1'b1;
                    endcase
                    if (op == OP_HALT) state_nxt = ST_HALT;
                    else               state_nxt = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (op == OP_STORE);
                if (mem_ack) begin
                    case (op)
                        OP_LOAD: begin acc_we = 1'b1; alu_sel = ALU_PASS; end
                        OP_ADD:  begin acc_we = 1'b1; alu_sel = ALU_ADD;  end
                        OP_SUB:  begin acc_we = 1'b1; alu_sel = ALU_SUB;  end
                        default: acc_we = 1'b0;
                    endcase
                    state_nxt = run ? ST_FETCH : ST_IDLE;
                end else if (timeout) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
`ifdef PATP_CTRL_MEM_TIMEOUT_EN
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef PATP_CTRL_MEM_TIMEOUT_EN
            // Any state change restarts the count, which covers every entry to FETCH or MEM.
            if (state_nxt != state) wait_cnt <= 4'd0;
            else                    wait_cnt <= wait_cnt + 4'd1;
            if (timeout && (state == ST_FETCH || state == ST_MEM)) err_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_patp_ctrl.sv
// Bench for patp_ctrl: instruction-level reference model expands each instruction into per-cycle expectations.
module tb_patp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [4:0] operand = 5'd0;
  logic       acc_zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_inc, pc_load, acc_we, halted, err;
  logic [1:0] alu_op;

  always #5 clk = ~clk;

  patp_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .operand(operand),
    .acc_zero(acc_zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_inc(pc_inc), .pc_load(pc_load),
    .acc_we(acc_we), .alu_op(alu_op), .halted(halted), .err(err)
  );

  typedef struct {
    logic       rst;
    logic       run;
    logic [2:0] opc;
    logic       az;
    logic       ack;
    logic       chk;
  } stim_t;

  stim_t       stim_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] obs;
  int          checks = 0;
  int          failures = 0;

  localparam logic [10:0] Z = 11'd0;

  assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_inc, pc_load, acc_we, alu_op, halted, err};

  function automatic logic [10:0] ov(input logic req, we, asel, irwe, pcinc, pcld, accwe,
                                     input logic [1:0] alu, input logic hlt, er);
    return {req, we, asel, irwe, pcinc, pcld, accwe, alu, hlt, er};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] ro();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [1:0] alu_of(input logic [2:0] opc);
    case (opc)
      3'd2:    return 2'd1;
      3'd3:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check_obs(input logic [10:0] e, input string tag, input int step);
    checks++;
    if (obs !== e) begin
      failures++;
      $error("FAIL %s step%0d {req,we,asel,irwe,pcinc,pcld,accwe,alu,hlt,err} got=%b want=%b",
             tag, step, obs, e);
    end
  endtask

  task automatic push(input logic r, rn, input logic [2:0] opc, input logic az, ack, chk,
                      input logic [10:0] e);
    stim_t s;
    s.rst = r; s.run = rn; s.opc = opc; s.az = az; s.ack = ack; s.chk = chk;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // One reset cycle, then one checked idle cycle with run low.
  task automatic do_reset();
    push(1'b1, 1'b0, ro(), rb(), rb(), 1'b0, Z);
    push(1'b0, 1'b0, ro(), rb(), rb(), 1'b1, Z);
  endtask

  task automatic start();
    push(1'b0, 1'b1, ro(), rb(), rb(), 1'b1, Z);
  endtask

  task automatic halt_tail(input int n, input logic er);
    for (int i = 0; i < n; i++)
      push(1'b0, rb(), ro(), rb(), rb(), 1'b1, ov(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, er));
  endtask

  // Expand one instruction: wf/wm wait cycles before ack, ra is run on the sampling cycle.
  task automatic gen_instr(input logic [2:0] opc, input int wf, wm, input logic az, ra);
    for (int i = 0; i < wf; i++)
      push(1'b0, rb(), opc, az, 1'b0, 1'b1, ov(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    push(1'b0, rb(), opc, az, 1'b1, 1'b1, ov(1, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0));
    if (opc < 3'd4) begin
      push(1'b0, rb(), opc, az, rb(), 1'b1, Z);
      for (int i = 0; i < wm; i++)
        push(1'b0, rb(), opc, az, 1'b0, 1'b1, ov(1, opc == 3'd1, 1, 0, 0, 0, 0, 2'd0, 0, 0));
      push(1'b0, ra, opc, az, 1'b1, 1'b1,
           ov(1, opc == 3'd1, 1, 0, 0, 0, opc != 3'd1, alu_of(opc), 0, 0));
    end else begin
      case (opc)
        3'd4:    push(1'b0, ra, opc, az, rb(), 1'b1, ov(0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0));
        3'd5:    push(1'b0, ra, opc, az, rb(), 1'b1, ov(0, 0, 0, 0, 0, az, 0, 2'd0, 0, 0));
        3'd6:    push(1'b0, ra, opc, az, rb(), 1'b1, ov(0, 0, 0, 0, 0, 0, 1, 2'd3, 0, 0));
        default: push(1'b0, rb(), opc, az, rb(), 1'b1, ov(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0));
      endcase
    end
    if (opc != 3'd7 && !ra) begin
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) push(1'b0, 1'b0, ro(), rb(), rb(), 1'b1, Z);
      push(1'b0, 1'b1, ro(), rb(), rb(), 1'b1, Z);
    end
  endtask

  initial begin
    stim_t       s;
    logic [10:0] e;
    int          step;
    logic        final_err;

    final_err = 1'b0;

    // LOAD; ADD; HALT with zero-wait memory
    do_reset();
    start();
    gen_instr(3'd0, 0, 0, 1'b0, 1'b1);
    gen_instr(3'd2, 0, 0, 1'b0, 1'b1);
    gen_instr(3'd7, 0, 0, 1'b0, 1'b1);
    halt_tail(3, 1'b0);

    // Delayed fetch ack, both BZ outcomes, STORE with a wait, JMP that drops to IDLE
    do_reset();
    start();
    gen_instr(3'd6, 3, 0, 1'b0, 1'b1);
    gen_instr(3'd5, 0, 0, 1'b1, 1'b1);
    gen_instr(3'd5, 0, 0, 1'b0, 1'b1);
    gen_instr(3'd1, 0, 2, 1'b0, 1'b1);
    gen_instr(3'd4, 1, 0, 1'b0, 1'b0);
    gen_instr(3'd3, 0, 1, 1'b1, 1'b0);
    gen_instr(3'd7, 0, 0, 1'b0, 1'b1);
    halt_tail(2, 1'b0);

    // Reset while a MEM request is outstanding
    do_reset();
    start();
    push(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, ov(1, 0, 0, 1, 1, 0, 0, 2'd0, 0, 0));
    push(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, Z);
    push(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, ov(1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    push(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, ov(1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0));
    push(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, Z);
    gen_instr(3'd7, 0, 0, 1'b0, 1'b1);
    halt_tail(2, 1'b0);

    // Randomized programs
    for (int p = 0; p < 5; p++) begin
      int n;
      do_reset();
      start();
      n = $urandom_range(5, 12);
      for (int k = 0; k < n; k++)
        gen_instr(3'($urandom_range(0, 6)), $urandom_range(0, 4), $urandom_range(0, 4),
                  rb(), $urandom_range(0, 3) != 0);
      gen_instr(3'd7, $urandom_range(0, 4), 0, rb(), rb());
      halt_tail($urandom_range(1, 4), 1'b0);
    end

`ifdef PATP_CTRL_MEM_TIMEOUT_EN
    // Ack on the 15th cycle of both FETCH and MEM completes normally
    do_reset();
    start();
    gen_instr(3'd0, 14, 14, 1'b0, 1'b1);
    gen_instr(3'd7, 0, 0, 1'b0, 1'b1);
    halt_tail(2, 1'b0);
    // Fetch never acked: 15 waiting cycles, then HALT with sticky err
    do_reset();
    start();
    for (int i = 0; i < 15; i++)
      push(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, ov(1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    halt_tail(3, 1'b1);
    final_err = 1'b1;
`endif

    // Reset-state check: reset held with run and ack high
    @(negedge clk);
    rst     = 1'b1;
    run     = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    #1;
    check_obs(Z, "reset_state", -1);

    step = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      rst      = s.rst;
      run      = s.run;
      opcode   = s.opc;
      operand  = 5'($urandom_range(0, 31));
      acc_zero = s.az;
      mem_ack  = s.ack;
      #1;
      if (s.chk) check_obs(e, "seq", step);
      step++;
    end

    @(negedge clk);
    #1;
    check_obs(ov(0, 0, 0, 0, 0, 0, 0, 2'd0, 1, final_err), "final_halt_err", step);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
